tff_updown_counter: RTL and testbench
=====================================

TFF_UPDOWN_COUNTER -- requirements
Module: tff_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RST_VAL, default 0, meaning the WIDTH-bit value loaded by reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset; it takes effect on its falling edge independent of clk.
REQ-005 The block SHALL have port clear  input  1  synchronous clear to zero.
REQ-006 The block SHALL have port load  input  1  synchronous parallel load.
REQ-007 The block SHALL have port load_val  input  WIDTH  the value loaded when load=1.
REQ-008 The block SHALL have port en  input  1  count enable.
REQ-009 The block SHALL have port up_dn  input  1  count direction; 1=up, 0=down.
REQ-010 The block SHALL have port q  output  WIDTH  the registered count.
REQ-011 The block SHALL have port tc  output  1  combinational terminal count.
REQ-012 The block SHALL have port wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-013 The block SHALL give the rising-edge actions priority clear > load > en; with none asserted, q SHALL hold.
REQ-014 The block SHALL implement the counter as WIDTH toggle cells: up count toggles bit i when en=1 and bits 0..i-1 are all 1; down count toggles bit i when en=1 and bits 0..i-1 are all 0; bit 0 toggles whenever counting.
REQ-015 The block SHALL drive tc = en & (up_dn ? q==all-ones : q==0), with no registering.
REQ-016 The block SHALL compute all arithmetic modulo 2^WIDTH: up from all-ones gives 0, and down from 0 gives all-ones.
REQ-017 The block SHALL register wrap high for exactly the one cycle following any edge where counting occurred while tc=1, and low otherwise.
REQ-018 The block SHALL not assert wrap on load or clear, even when the loaded value is a terminal value.
REQ-019 The block SHALL give load or clear precedence over en in the same cycle, so the count step is discarded and wrap=0 next cycle.
REQ-020 The block SHALL let a change of up_dn take effect on the next rising edge, with no extra latency.
REQ-021 The block SHALL show a count, load or clear in q one cycle after the enabling edge.

Reset
REQ-022 While reset=0, the block SHALL force q=RST_VAL and wrap=0 asynchronously, and tc SHALL follow REQ-015.
REQ-023 On reset deassertion, the block SHALL perform no state change until the first rising clk edge with reset=1.
REQ-024 If reset is asserted mid-count, the block SHALL discard the in-flight step, and no wrap pulse SHALL appear after release.

Configuration
REQ-025 When macro TFF_CNT_SATURATE_EN is defined, the block SHALL add input port sat_mode (1 bit).
REQ-026 With TFF_CNT_SATURATE_EN defined and sat_mode=1, the block SHALL hold q at all-ones (up) or 0 (down) instead of wrapping, and wrap SHALL stay 0.
REQ-027 With TFF_CNT_SATURATE_EN defined and sat_mode=0, the block SHALL wrap as in REQ-016.
REQ-028 Without TFF_CNT_SATURATE_EN, the block SHALL have no sat_mode port and SHALL always wrap.

Structure
REQ-029 The design SHALL use a shared package tff_pkg holding the direction constants DIR_UP=1 and DIR_DN=0, plus a function that computes the toggle-enable vector from q, up_dn and en.
REQ-030 The design SHALL use one sub-module, tff_cell: a single T flip-flop with clk, active-low async reset, a reset-value input, sync clear/load, and a toggle input; the counter SHALL instantiate WIDTH copies in a generate loop.
REQ-031 The block SHALL contain no latches or derived clocks, and every flop SHALL be on clk.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-032 The bench SHALL check reset: drop reset mid-cycle with en=1 -> q=0 immediately, with no clk edge needed; wrap=0; q holds at 0 after release until the first enabled edge.
REQ-033 The bench SHALL check up wrap: en=1, up_dn=1 from 0 for 16 edges -> q steps 1..15 then 0; tc=1 while q=15; wrap=1 for exactly the one cycle after the 15->0 step.
REQ-034 The bench SHALL check down count: load 4'h2, then en=1, up_dn=0 -> q=2,1,0,15; wrap pulses once after the 0->15 step.
REQ-035 The bench SHALL check priority: clear=1, load=1 (load_val=9), en=1 on one edge -> q=0; then load=1, en=1 -> q=9; load of 15 followed by a hold -> wrap stays 0.
REQ-036 The bench SHALL check direction flip: q=7, en=1, up_dn toggled on every edge -> q=8,7,8,7.
REQ-037 The bench SHALL check saturation, with TFF_CNT_SATURATE_EN defined and sat_mode=1: count up past 15 -> q stays 15, tc=1, wrap=0; then count down from 0 -> q stays 0.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-flip-flop up/down counter:
// direction encodings and the toggle-enable vector computation.
package tff_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MAX_WIDTH = 32;

    // Bit i toggles when counting and every lower bit is 1 (up) or 0 (down).
    // Bit 0 toggles whenever counting. Callers zero-extend q to MAX_WIDTH and
    // keep only their low WIDTH bits of the result.
    function automatic logic [MAX_WIDTH-1:0] toggle_vec(
        input logic [MAX_WIDTH-1:0] q,
        input logic                 up_dn,
        input logic                 en
    );
        logic [MAX_WIDTH-1:0] t;
        logic                 run;
        t   = '0;
        run = en;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            t[i] = run;
            run  = run & ((up_dn == DIR_UP) ? q[i] : ~q[i]);
        end
        return t;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop cell: async active-low reset to a supplied value,
// synchronous clear and load, otherwise toggles when toggle=1.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic clear,
    input  logic load,
    input  logic load_bit,
    input  logic toggle,
    output logic q
);

    // Priority: reset (async) > clear > load > toggle > hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= rst_val;
        end else if (clear) begin
            q <= 1'b0;
        end else if (load) begin
            q <= load_bit;
        end else if (toggle) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// WIDTH-bit up/down counter built from T flip-flop cells.
// tc is combinational terminal count; wrap is a registered one-cycle pulse
// after a counting edge taken while tc=1.
// Optional feature: define TFF_CNT_SATURATE_EN to add the sat_mode input,
// which makes the counter stop at all-ones (up) or zero (down).
module tff_updown_counter
    import tff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef TFF_CNT_SATURATE_EN
    input  logic             sat_mode,
`endif
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [MAX_WIDTH-1:0] q_ext;
    logic [WIDTH-1:0]     toggle;
    logic                 at_ones;
    logic                 at_zero;
    logic                 sat_hold;
    logic                 count_en;

    // Terminal detection, saturation gating and toggle-enable generation.
    always_comb begin
        at_ones = &q;
        at_zero = ~|q;
        tc      = en & ((up_dn == DIR_DN) ? at_zero : at_ones);
`ifdef TFF_CNT_SATURATE_EN
        sat_hold = sat_mode & tc;
`else
        sat_hold = 1'b0;
`endif
        count_en = en & ~sat_hold;
        q_ext    = MAX_WIDTH'(q);
        toggle   = WIDTH'(toggle_vec(q_ext, up_dn, count_en));
    end

    // One T flip-flop per count bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk      (clk),
            .reset    (reset),
            .rst_val  (RST_VAL[i]),
            .clear    (clear),
            .load     (load),
            .load_bit (load_val[i]),
            .toggle   (toggle[i]),
            .q        (q[i])
        );
    end

    // Wrap pulse: only a real counting step from a terminal value; clear,
    // load and saturation all suppress it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc & ~clear & ~load & ~sat_hold;
        end
    end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed self-checking bench for tff_updown_counter (WIDTH=4, RST_VAL=0).
module tb_tff_updown_counter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         up_dn;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
`ifdef TFF_CNT_SATURATE_EN
    logic         sat_mode;
`endif

    int n_cmp;
    int n_err;

    tff_updown_counter #(.WIDTH(W), .RST_VAL(4'h0)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef TFF_CNT_SATURATE_EN
        .sat_mode (sat_mode),
`endif
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up_dn    (up_dn),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        en = 1'b1; up_dn = 1'b1;
        tick(); tick(); tick();
        #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'h0) begin n_err++; $display("FAIL reset_async_q: got %0h want 0", q); end
        n_cmp++;
        if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_async_wrap: got %0b want 0", wrap); end
        n_cmp++;
        if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %0b want 0", tc); end
        tick();
        n_cmp++;
        if (q !== 4'h0) begin n_err++; $display("FAIL reset_held_q: got %0h want 0", q); end
        #2;
        en = 1'b0;
        reset = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h0) begin n_err++; $display("FAIL reset_release_hold: got %0h want 0", q); end
        en = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h1) begin n_err++; $display("FAIL reset_first_count: got %0h want 1", q); end
    endtask

    task automatic test_up_wrap();
        en = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (q !== 4'h0) begin n_err++; $display("FAIL up_clear: got %0h want 0", q); end
        en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            n_cmp++;
            if (tc !== (k == 16)) begin n_err++; $display("FAIL up_tc step %0d: got %0b want %0b", k, tc, (k == 16)); end
            tick();
            n_cmp++;
            if (q !== W'(k % 16)) begin n_err++; $display("FAIL up_q step %0d: got %0h want %0h", k, q, k % 16); end
            n_cmp++;
            if (wrap !== (k == 16)) begin n_err++; $display("FAIL up_wrap step %0d: got %0b want %0b", k, wrap, (k == 16)); end
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (wrap !== 1'b0 || q !== 4'h0) begin n_err++; $display("FAIL up_after_wrap: got q=%0h wrap=%0b want q=0 wrap=0", q, wrap); end
    endtask

    task automatic test_down();
        logic [W-1:0] exp_q [4];
        exp_q = '{4'h1, 4'h0, 4'hF, 4'hE};
        load = 1'b1; load_val = 4'h2; en = 1'b0;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'h2 || wrap !== 1'b0) begin n_err++; $display("FAIL down_load: got q=%0h wrap=%0b want q=2 wrap=0", q, wrap); end
        en = 1'b1; up_dn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (tc !== (k == 2)) begin n_err++; $display("FAIL down_tc step %0d: got %0b want %0b", k, tc, (k == 2)); end
            tick();
            n_cmp++;
            if (q !== exp_q[k]) begin n_err++; $display("FAIL down_q step %0d: got %0h want %0h", k, q, exp_q[k]); end
            n_cmp++;
            if (wrap !== (k == 2)) begin n_err++; $display("FAIL down_wrap step %0d: got %0b want %0b", k, wrap, (k == 2)); end
        end
        en = 1'b0;
    endtask

    task automatic test_priority();
        clear = 1'b1; load = 1'b1; load_val = 4'h9; en = 1'b1; up_dn = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h0 || wrap !== 1'b0) begin n_err++; $display("FAIL prio_clear: got q=%0h wrap=%0b want q=0 wrap=0", q, wrap); end
        clear = 1'b0;
        tick();
        n_cmp++;
        if (q !== 4'h9) begin n_err++; $display("FAIL prio_load: got %0h want 9", q); end
        load_val = 4'hF;
        tick();
        n_cmp++;
        if (q !== 4'hF || wrap !== 1'b0) begin n_err++; $display("FAIL prio_load15: got q=%0h wrap=%0b want q=f wrap=0", q, wrap); end
        load = 1'b0; en = 1'b0;
        tick();
        n_cmp++;
        if (q !== 4'hF || wrap !== 1'b0 || tc !== 1'b0) begin n_err++; $display("FAIL prio_hold: got q=%0h wrap=%0b tc=%0b want q=f wrap=0 tc=0", q, wrap, tc); end
        en = 1'b1; clear = 1'b1;
        #1;
        n_cmp++;
        if (tc !== 1'b1) begin n_err++; $display("FAIL prio_tc15: got %0b want 1", tc); end
        tick();
        n_cmp++;
        if (q !== 4'h0 || wrap !== 1'b0) begin n_err++; $display("FAIL prio_clear_at_tc: got q=%0h wrap=%0b want q=0 wrap=0", q, wrap); end
        clear = 1'b0; en = 1'b0;
    endtask

    task automatic test_dir_flip();
        logic [W-1:0] exp_q [4];
        exp_q = '{4'h8, 4'h7, 4'h8, 4'h7};
        load = 1'b1; load_val = 4'h7;
        tick();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up_dn = (k % 2 == 0);
            tick();
            n_cmp++;
            if (q !== exp_q[k]) begin n_err++; $display("FAIL flip_q step %0d: got %0h want %0h", k, q, exp_q[k]); end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_midcount();
        load = 1'b1; load_val = 4'hF;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'h0 || wrap !== 1'b0) begin n_err++; $display("FAIL midrst_async: got q=%0h wrap=%0b want q=0 wrap=0", q, wrap); end
        tick();
        #2;
        en = 1'b0;
        reset = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h0 || wrap !== 1'b0) begin n_err++; $display("FAIL midrst_after: got q=%0h wrap=%0b want q=0 wrap=0", q, wrap); end
    endtask

`ifdef TFF_CNT_SATURATE_EN
    task automatic test_saturate();
        sat_mode = 1'b1;
        load = 1'b1; load_val = 4'hE;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (q !== 4'hF || tc !== 1'b1 || wrap !== 1'b0) begin n_err++; $display("FAIL sat_up step %0d: got q=%0h tc=%0b wrap=%0b want q=f tc=1 wrap=0", k, q, tc, wrap); end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0; up_dn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (q !== 4'h0 || wrap !== 1'b0) begin n_err++; $display("FAIL sat_dn step %0d: got q=%0h wrap=%0b want q=0 wrap=0", k, q, wrap); end
        end
        sat_mode = 1'b0;
        tick();
        n_cmp++;
        if (q !== 4'hF || wrap !== 1'b1) begin n_err++; $display("FAIL sat_off_wrap: got q=%0h wrap=%0b want q=f wrap=1", q, wrap); end
        en = 1'b0;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef TFF_CNT_SATURATE_EN
        sat_mode = 1'b0;
`endif
        test_reset();
        test_up_wrap();
        test_down();
        test_priority();
        test_dir_flip();
        test_reset_midcount();
`ifdef TFF_CNT_SATURATE_EN
        test_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
